conv_row_feeder: RTL and testbench

CONV_ROW_FEEDER -- requirements
Module: conv_row_feeder

---
 rtl/conv_row_feeder_pkg.sv | 19 +
 rtl/conv_row_feeder_row_pad.sv | 29 ++
 rtl/conv_row_feeder.sv | 136 +++++++++++++
 tb/tb_conv_row_feeder.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_row_feeder_pkg.sv
// Shared constants and types for the convolution front-end blocks.
package conv_row_feeder_pkg;

    // Zero border added on each side of a row for a 3x3 window.
    localparam int PAD = 1;

    // Row width once the zero border is added on both sides.
    function automatic int padded_width(input int w);
        return w + 2 * PAD;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } feeder_state_e;

endpackage

// File: rtl/conv_row_feeder_row_pad.sv
// Adds a one-pixel zero border on both sides of every channel of a row.
module row_pad
    import conv_row_feeder_pkg::*;
#(
    parameter int D          = 4,
    parameter int W          = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH*D*W-1:0]                row_i,
    output logic [DATA_WIDTH*D*padded_width(W)-1:0] row_o
);

    localparam int WP = padded_width(W);

    genvar gi, gj;
    generate
        for (gi = 0; gi < D; gi++) begin : g_chan
            // Border pixels of each channel are tied to zero.
            assign row_o[DATA_WIDTH*WP*gi +: DATA_WIDTH]                      = '0;
            assign row_o[DATA_WIDTH*WP*gi + DATA_WIDTH*(WP-1) +: DATA_WIDTH] = '0;
            for (gj = 0; gj < W; gj++) begin : g_pix
                // Input pixel j lands one slot to the right in the padded row.
                assign row_o[DATA_WIDTH*WP*gi + DATA_WIDTH*(gj+PAD) +: DATA_WIDTH] =
                    row_i[DATA_WIDTH*W*gi + DATA_WIDTH*gj +: DATA_WIDTH];
            end
        end
    endgenerate

endmodule

// File: rtl/conv_row_feeder.sv
// Buffers three padded image rows and hands 3-row windows to a conv pipeline,
// one window per conv_done handshake, with zero rows above and below the frame.
module conv_row_feeder
    import conv_row_feeder_pkg::*;
#(
    parameter int D          = 4,
    parameter int H          = 12,
    parameter int W          = 12,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                     clk,
    input  logic                                     rstn_i,
    input  logic [DATA_WIDTH*D*W-1:0]                row_i,
    input  logic                                     row_valid_i,
    output logic                                     row_ready_o,
    output logic [DATA_WIDTH*D*padded_width(W)-1:0] image0,
    output logic [DATA_WIDTH*D*padded_width(W)-1:0] image1,
    output logic [DATA_WIDTH*D*padded_width(W)-1:0] image2,
    output logic                                     image_start,
    input  logic                                     conv_done_i,
    output logic                                     frame_done_o,
    output logic                                     busy_o
);

    localparam int ROW_BITS = DATA_WIDTH * D * padded_width(W);
    localparam int CNT_W    = $clog2(H) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(H - 1);
    // For H==1 this value is never reached because CNT_LAST is tested first.
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'((H > 1) ? H - 2 : 0);

    logic [ROW_BITS-1:0] padded_row;
    logic [ROW_BITS-1:0] top_q, mid_q, bot_q;
    feeder_state_e       state_q;
    logic [CNT_W-1:0]    win_cnt_q, win_cnt_d;
    logic                ready_q, start_q, done_q, busy_q;
    logic                accept;

    row_pad #(
        .D          (D),
        .W          (W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_row_pad (
        .row_i (row_i),
        .row_o (padded_row)
    );

    assign accept    = row_valid_i & ready_q;
    assign win_cnt_d = win_cnt_q + CNT_W'(1);

    // Window sequencer; ready/start/done/busy are registered alongside the state.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            top_q     <= '0;
            mid_q     <= '0;
            bot_q     <= '0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    if (accept) begin
                        top_q     <= '0;
                        mid_q     <= padded_row;
                        win_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        if (H == 1) begin
                            bot_q   <= '0;
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        bot_q   <= padded_row;
                        state_q <= ST_ISSUE;
                        start_q <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (conv_done_i) begin
                        if (win_cnt_q == CNT_LAST) begin
                            state_q <= ST_IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            // Shift the window down one row; bot is refilled in LOAD
                            // or stays zero for the bottom border window.
                            top_q     <= mid_q;
                            mid_q     <= bot_q;
                            bot_q     <= '0;
                            win_cnt_q <= win_cnt_d;
                            if (win_cnt_q == CNT_PENULT) begin
                                state_q <= ST_ISSUE;
                                start_q <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                                ready_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign row_ready_o  = ready_q;
    assign image0       = top_q;
    assign image1       = mid_q;
    assign image2       = bot_q;
    assign image_start  = start_q;
    assign frame_done_o = done_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_conv_row_feeder.sv
// Directed bench: an H=3 feeder for the main frame flow, hold and reset cases,
// plus an H=1 feeder for the single-row frame.
module tb_conv_row_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;

    logic [15:0] a_row;
    logic        a_valid, a_ready, a_conv, a_start, a_fdone, a_busy;
    logic [31:0] a_img0, a_img1, a_img2;

    logic [15:0] b_row;
    logic        b_valid, b_ready, b_conv, b_start, b_fdone, b_busy;
    logic [31:0] b_img0, b_img1, b_img2;

    int vectors     = 0;
    int miscompares = 0;

    conv_row_feeder #(.D(1), .H(3), .W(2), .DATA_WIDTH(8)) u_dut_a (
        .clk          (clk),
        .rstn_i       (rstn),
        .row_i        (a_row),
        .row_valid_i  (a_valid),
        .row_ready_o  (a_ready),
        .image0       (a_img0),
        .image1       (a_img1),
        .image2       (a_img2),
        .image_start  (a_start),
        .conv_done_i  (a_conv),
        .frame_done_o (a_fdone),
        .busy_o       (a_busy)
    );

    conv_row_feeder #(.D(1), .H(1), .W(2), .DATA_WIDTH(8)) u_dut_b (
        .clk          (clk),
        .rstn_i       (rstn),
        .row_i        (b_row),
        .row_valid_i  (b_valid),
        .row_ready_o  (b_ready),
        .image0       (b_img0),
        .image1       (b_img1),
        .image2       (b_img2),
        .image_start  (b_start),
        .conv_done_i  (b_conv),
        .frame_done_o (b_fdone),
        .busy_o       (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Padded row for W=2, D=1: zero, pixel0, pixel1, zero (pixel0 in the low byte).
    function automatic logic [31:0] pad(input logic [15:0] r);
        return {8'h00, r[15:8], r[7:0], 8'h00};
    endfunction

    // Wait (bounded) for ready, present the row for one edge; returns at the
    // falling edge right after the accepting rising edge.
    task automatic send_a(input logic [15:0] d);
        int n;
        n = 0;
        while (!a_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("a ready before send", a_ready, 1);
        a_row   = d;
        a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
    endtask

    task automatic conv_a();
        a_conv = 1'b1;
        @(negedge clk);
        a_conv = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] r0, input logic [15:0] r1, input logic [15:0] r2);
        send_a(r0);
        chk("f load start", a_start, 0);
        chk("f load busy", a_busy, 1);
        chk("f load ready", a_ready, 1);
        send_a(r1);
        chk("w0 start", a_start, 1);
        chk("w0 img0", a_img0, 32'h0);
        chk("w0 img1", a_img1, pad(r0));
        chk("w0 img2", a_img2, pad(r1));
        @(negedge clk);
        chk("w0 start pulse ends", a_start, 0);
        chk("w0 wait ready", a_ready, 0);
        conv_a();
        chk("w0 done -> load ready", a_ready, 1);
        chk("w0 done no start", a_start, 0);
        send_a(r2);
        chk("w1 start", a_start, 1);
        chk("w1 img0", a_img0, pad(r0));
        chk("w1 img1", a_img1, pad(r1));
        chk("w1 img2", a_img2, pad(r2));
        @(negedge clk);
        conv_a();
        chk("w2 start", a_start, 1);
        chk("w2 no accept", a_ready, 0);
        chk("w2 img0", a_img0, pad(r1));
        chk("w2 img1", a_img1, pad(r2));
        chk("w2 img2", a_img2, 32'h0);
        @(negedge clk);
        conv_a();
        chk("frame_done", a_fdone, 1);
        chk("end busy", a_busy, 0);
        chk("end ready", a_ready, 1);
        @(negedge clk);
        chk("frame_done pulse ends", a_fdone, 0);
    endtask

    initial begin
        int starts;
        int readies;

        rstn    = 1'b1;
        a_row   = '0; a_valid = 1'b0; a_conv = 1'b0;
        b_row   = '0; b_valid = 1'b0; b_conv = 1'b0;
        #1 rstn = 1'b0;
        #2;
        chk("rst img0", a_img0, 32'h0);
        chk("rst img1", a_img1, 32'h0);
        chk("rst img2", a_img2, 32'h0);
        chk("rst start/done/busy/ready", {a_start, a_fdone, a_busy, a_ready}, 4'b0000);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("ready low before first edge", a_ready, 0);
        @(negedge clk);
        chk("ready after first edge", a_ready, 1);
        chk("idle busy", a_busy, 0);

        // Full frame with the reference rows.
        run_frame(16'h0201, 16'h0403, 16'h0605);

        // Valid held high through WAIT must not be accepted.
        send_a(16'h0201);
        send_a(16'h0403);
        @(negedge clk);
        a_row   = 16'hBEEF;
        a_valid = 1'b1;
        starts  = 0;
        readies = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            starts  += int'(a_start);
            readies += int'(a_ready);
        end
        a_valid = 1'b0;
        chk("hold extra starts", starts, 0);
        chk("hold ready highs", readies, 0);
        chk("hold img1 stable", a_img1, pad(16'h0201));
        chk("hold img2 stable", a_img2, pad(16'h0403));
        conv_a();
        send_a(16'h0605);
        chk("post-hold img2", a_img2, pad(16'h0605));
        @(negedge clk);

        // Reset during window1 WAIT drops the frame.
        #2 rstn = 1'b0;
        #1;
        chk("midrst img0", a_img0, 32'h0);
        chk("midrst img1", a_img1, 32'h0);
        chk("midrst img2", a_img2, 32'h0);
        chk("midrst flags", {a_start, a_fdone, a_busy, a_ready}, 4'b0000);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("post-rst ready", a_ready, 1);
        run_frame(16'h1211, 16'h1413, 16'h1615);

        // Single-row frame on the H=1 instance.
        chk("b ready", b_ready, 1);
        b_row   = 16'h0201;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        chk("b start", b_start, 1);
        chk("b img0", b_img0, 32'h0);
        chk("b img1", b_img1, 32'h00020100);
        chk("b img2", b_img2, 32'h0);
        chk("b busy", b_busy, 1);
        @(negedge clk);
        b_conv = 1'b1;
        @(negedge clk);
        b_conv = 1'b0;
        chk("b frame_done", b_fdone, 1);
        chk("b end busy", b_busy, 0);
        chk("b end ready", b_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
